// File: rtl/dlatch_driver.sv
// dlatch_driver: LFSR-scheduled stimulus generator and self-checker for a
// level-sensitive dlatch2 cell. Drives d/en/rstn, compares q every cycle.
module dlatch_driver #(
  parameter int          NUM_ITER = 5,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          RST_CYC  = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       q_in,
  output logic       d_out,
  output logic       en_out,
  output logic       rstn_out,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] err_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // Counter must hold both RST_CYC-1 and the 3-bit random delays.
  localparam int CNT_W = $clog2(RST_CYC + 8);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_CYC - 1);
  localparam logic [7:0] ITER_LAST = 8'(NUM_ITER);

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    REL_WAIT,
    DRAW,
    WAIT_EN,
    WAIT_D,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       iter_reg, iter_next;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [2:0]       dly_reg, dly_next;
  logic             d_reg, d_next;
  logic             en_reg, en_next;
  logic             rstn_reg, rstn_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             mism_reg, mism_next;
  logic [7:0]       err_reg, err_next;
  logic             expq_reg, expq_next;

  logic             exp_now;
  logic             miscmp;
  logic [7:0]       iter_inc;
  logic [15:0]      lfsr_adv;

  assign d_out     = d_reg;
  assign en_out    = en_reg;
  assign rstn_out  = rstn_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mismatch  = mism_reg;
  assign err_count = err_reg;

  // State register; reset returns everything, including the LFSR, to power-up values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      iter_reg  <= 8'd0;
      lfsr_reg  <= SEED_EFF;
      dly_reg   <= 3'd0;
      d_reg     <= 1'b0;
      en_reg    <= 1'b0;
      rstn_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      mism_reg  <= 1'b0;
      err_reg   <= 8'd0;
      expq_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iter_reg  <= iter_next;
      lfsr_reg  <= lfsr_next;
      dly_reg   <= dly_next;
      d_reg     <= d_next;
      en_reg    <= en_next;
      rstn_reg  <= rstn_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      mism_reg  <= mism_next;
      err_reg   <= err_next;
      expq_reg  <= expq_next;
    end
  end

  // Next-state, stimulus schedule, reference latch model and checker.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    iter_next  = iter_reg;
    lfsr_next  = lfsr_reg;
    dly_next   = dly_reg;
    d_next     = d_reg;
    en_next    = en_reg;
    rstn_next  = rstn_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    mism_next  = mism_reg;
    err_next   = err_reg;

    // The latch under test is transparent, so its q this cycle follows the
    // outputs presented this cycle; compare against the model's new value.
    exp_now   = !rstn_reg ? 1'b0 : (en_reg ? d_reg : expq_reg);
    expq_next = exp_now;
    miscmp    = (state_reg != IDLE) && (q_in != exp_now);
    iter_inc  = iter_reg + 8'd1;
    lfsr_adv  = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    if (miscmp) begin
      mism_next = 1'b1;
      if (err_reg != 8'hFF) begin
        err_next = err_reg + 8'd1;
      end
    end

    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == IDLE) begin
          rstn_next = 1'b0;
          d_next    = 1'b0;
          en_next   = 1'b0;
        end
        // Starting a run clears the result flags; this wins over a
        // miscompare detected in the same cycle.
        if (start) begin
          state_next = RST_HOLD;
          cnt_next   = HOLD_LOAD;
          iter_next  = 8'd0;
          rstn_next  = 1'b0;
          d_next     = 1'b0;
          en_next    = 1'b0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          mism_next  = 1'b0;
          err_next   = 8'd0;
        end
      end
      RST_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = REL_WAIT;
          cnt_next   = HOLD_LOAD;
          rstn_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      REL_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DRAW;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DRAW: begin
        dly_next   = lfsr_reg[2:0];
        cnt_next   = CNT_W'(lfsr_reg[4:3]);
        lfsr_next  = lfsr_adv;
        state_next = WAIT_EN;
      end
      WAIT_EN: begin
        if (cnt_reg == '0) begin
          en_next    = ~en_reg;
          cnt_next   = CNT_W'(dly_reg);
          state_next = WAIT_D;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      WAIT_D: begin
        if (cnt_reg == '0) begin
          d_next    = iter_reg[0];
          iter_next = iter_inc;
          if (iter_inc == ITER_LAST) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = DRAW;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
